// File: rtl/glitch_sweep_seq.sv
// Reset-and-glitch attempt sequencer with an automatic (delay, width) sweep.
// Optional hit lock is built when GLITCH_HIT_LOCK_EN is defined.
module glitch_sweep_seq #(
    parameter int unsigned CH         = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RESET_LEN  = 512,
    parameter int unsigned DELAY_MIN  = 1,
    parameter int unsigned DELAY_MAX  = 768,
    parameter int unsigned WIDTH_MIN  = 384,
    parameter int unsigned WIDTH_MAX  = 640,
    parameter int unsigned CH_STAGGER = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic [CH-1:0]    i_ch_mask,
    input  logic             i_hit,
    input  logic             i_clear,
    output logic             o_reset_out_n,
    output logic [CH-1:0]    o_glitch,
    output logic             o_busy,
    output logic             o_locked,
    output logic             o_done,
    output logic             o_wrap,
    output logic [CNT_W-1:0] o_cur_delay,
    output logic [CNT_W-1:0] o_cur_width,
    output logic [15:0]      o_attempt
);

    // Phase counter needs headroom for W plus up to seven stagger offsets.
    localparam int unsigned PH_W = CNT_W + 4;

    localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
    localparam logic [PH_W-1:0]  RST_LAST   = PH_W'(RESET_LEN - 1);
    localparam logic [PH_W-1:0]  STAG_TOT   = PH_W'((CH - 1) * CH_STAGGER);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] D_MIN      = CNT_W'(DELAY_MIN);
    localparam logic [CNT_W-1:0] D_MAX      = CNT_W'(DELAY_MAX);
    localparam logic [CNT_W-1:0] W_MIN      = CNT_W'(WIDTH_MIN);
    localparam logic [CNT_W-1:0] W_MAX      = CNT_W'(WIDTH_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StRst,
        StWait,
        StFire
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [PH_W-1:0]   r_cnt;
    logic [PH_W-1:0]   w_cnt_d;
    logic [CH-1:0]     r_mask;
    logic [CNT_W-1:0]  r_delay;
    logic [CNT_W-1:0]  r_width;
    logic [CNT_W-1:0]  r_cur_delay;
    logic [CNT_W-1:0]  r_cur_width;
    logic [CNT_W-1:0]  w_cur_delay_d;
    logic [CNT_W-1:0]  w_cur_width_d;
    logic [15:0]       r_attempt;
    logic              r_done;
    logic              r_wrap;
    logic              r_busy;
    logic              r_reset_n;
    logic [CH-1:0]     r_glitch;
    logic [CH-1:0]     w_glitch_d;
    logic              w_done_d;
    logic              w_wrap_d;
    logic              w_latch;
    logic              w_hit;
    logic              w_locked;
    logic              w_fire_d;
    logic [PH_W-1:0]   w_delay_last;
    logic [PH_W-1:0]   w_fire_last;

`ifdef GLITCH_HIT_LOCK_EN
    logic r_locked;

    assign w_hit    = i_hit;
    assign w_locked = r_locked;

    // HIT beats CLEAR when both arrive together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_locked <= 1'b0;
        end else if (i_hit) begin
            r_locked <= 1'b1;
        end else if (i_clear) begin
            r_locked <= 1'b0;
        end
    end
`else
    logic w_unused_hit_clear;

    assign w_hit              = 1'b0;
    assign w_locked           = 1'b0;
    assign w_unused_hit_clear = i_hit ^ i_clear;
`endif

    assign w_delay_last = PH_W'(r_delay) - PH_ONE;
    assign w_fire_last  = PH_W'(r_width) + STAG_TOT - PH_ONE;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_done_d  = 1'b0;
        w_latch   = 1'b0;
        unique case (r_state)
            StIdle: begin
                // ARM coinciding with the DONE pulse is dropped.
                if (i_arm && !w_locked && !r_done) begin
                    w_state_d = StRst;
                    w_cnt_d   = '0;
                    w_latch   = 1'b1;
                end
            end
            StRst: begin
                if (r_cnt == RST_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = (r_delay == CNT_ZERO) ? StFire : StWait;
                end else begin
                    w_cnt_d = r_cnt + PH_ONE;
                end
            end
            StWait: begin
                if (r_cnt == w_delay_last) begin
                    w_cnt_d   = '0;
                    w_state_d = StFire;
                end else begin
                    w_cnt_d = r_cnt + PH_ONE;
                end
            end
            StFire: begin
                if (r_cnt == w_fire_last) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + PH_ONE;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase

        if (w_hit || (i_abort && (r_state != StIdle))) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_done_d  = 1'b0;
            w_latch   = 1'b0;
        end
    end

    always_comb begin
        w_cur_delay_d = r_cur_delay;
        w_cur_width_d = r_cur_width;
        w_wrap_d      = 1'b0;
        if (w_done_d) begin
            if (r_cur_delay < D_MAX) begin
                w_cur_delay_d = r_cur_delay + CNT_ONE;
            end else begin
                w_cur_delay_d = D_MIN;
                if (r_cur_width < W_MAX) begin
                    w_cur_width_d = r_cur_width + CNT_ONE;
                end else begin
                    w_cur_width_d = W_MIN;
                    w_wrap_d      = 1'b1;
                end
            end
        end
    end

    assign w_fire_d = (w_state_d == StFire);

    // FIRE is never entered from IDLE, so the latched mask/width are valid here.
    for (genvar k = 0; k < CH; k++) begin : g_ch
        localparam logic [PH_W-1:0] START = PH_W'(k * CH_STAGGER);
        assign w_glitch_d[k] = w_fire_d && r_mask[k] && (w_cnt_d >= START) &&
                               (w_cnt_d < START + PH_W'(r_width));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_delay     <= D_MIN;
            r_width     <= W_MIN;
            r_cur_delay <= D_MIN;
            r_cur_width <= W_MIN;
            r_attempt   <= '0;
            r_done      <= 1'b0;
            r_wrap      <= 1'b0;
            r_busy      <= 1'b0;
            r_reset_n   <= 1'b1;
            r_glitch    <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_cur_delay <= w_cur_delay_d;
            r_cur_width <= w_cur_width_d;
            r_done      <= w_done_d;
            r_wrap      <= w_wrap_d;
            r_busy      <= (w_state_d != StIdle);
            r_reset_n   <= (w_state_d != StRst);
            r_glitch    <= w_glitch_d;
            if (w_latch) begin
                r_mask  <= i_ch_mask;
                r_delay <= r_cur_delay;
                r_width <= r_cur_width;
            end
            if (w_done_d) begin
                r_attempt <= r_attempt + 16'd1;
            end
        end
    end

    assign o_reset_out_n = r_reset_n;
    assign o_glitch      = r_glitch;
    assign o_busy        = r_busy;
    assign o_locked      = w_locked;
    assign o_done        = r_done;
    assign o_wrap        = r_wrap;
    assign o_cur_delay   = r_cur_delay;
    assign o_cur_width   = r_cur_width;
    assign o_attempt     = r_attempt;

endmodule
